dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the two-port data-memory arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requests and memory.
interface dmem_arbiter_if;
  logic        r0_req;
  logic        r0_we;
  logic [1:0]  r0_size;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r0_err;

  logic        r1_req;
  logic        r1_we;
  logic [1:0]  r1_size;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [31:0] r1_rdata;
  logic        r1_err;

  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_size;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  r0_req, r0_we, r0_size, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_size, r1_addr, r1_wdata,
    input  read_data,
    output r0_gnt, r0_rvalid, r0_rdata, r0_err,
    output r1_gnt, r1_rvalid, r1_rdata, r1_err,
    output mem_write, mem_read, mem_size, address, write_data
  );

  modport master (
    output r0_req, r0_we, r0_size, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_size, r1_addr, r1_wdata,
    output read_data,
    input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
    input  mem_write, mem_read, mem_size, address, write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the core LSU (r0) and debug/DMA (r1) for one data memory.
// Define DMEM_ARB_ALIGN_CHK_EN to also reject misaligned half/word accesses.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic              clk,
  input logic              rst,
  dmem_arbiter_if.slave    bus_io
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;

  logic        gnt0, gnt1, any_gnt, sel;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        illegal, legal;

  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0]       resp_vis;

  // Contended requests go to whichever requester did not win last time.
  always_comb begin
    gnt0    = !rst && bus_io.r0_req && (!bus_io.r1_req || last_grant_q);
    gnt1    = !rst && bus_io.r1_req && (!bus_io.r0_req || !last_grant_q);
    any_gnt = gnt0 || gnt1;
    sel     = gnt1;
    sel_we    = sel ? bus_io.r1_we    : bus_io.r0_we;
    sel_size  = sel ? bus_io.r1_size  : bus_io.r0_size;
    sel_addr  = sel ? bus_io.r1_addr  : bus_io.r0_addr;
    sel_wdata = sel ? bus_io.r1_wdata : bus_io.r0_wdata;
  end

  always_comb begin
    nbytes = 3'd0;
    unique case (sel_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap into range.
    end_addr = {1'b0, sel_addr} + {30'd0, nbytes};
    illegal  = (sel_size == 2'b11) || (end_addr > 33'(MEM_BYTES));
`ifdef DMEM_ARB_ALIGN_CHK_EN
    if ((sel_size == 2'b01) && sel_addr[0]) illegal = 1'b1;
    if ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00)) illegal = 1'b1;
`endif
    legal = any_gnt && !illegal;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      rvalid_q     <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = any_gnt ? StResp : StIdle;
      StResp:  state_d = any_gnt ? StResp : StIdle;
      default: state_d = StIdle;
    endcase
    last_grant_d = any_gnt ? sel : last_grant_q;
    rvalid_d     = {gnt1, gnt0};
    err_d        = {gnt1 && illegal, gnt0 && illegal};
    rdata_d[0]   = (gnt0 && legal && !sel_we) ? bus_io.read_data : 32'd0;
    rdata_d[1]   = (gnt1 && legal && !sel_we) ? bus_io.read_data : 32'd0;
  end

  // Outputs; a response pending while rst is high is hidden so it is effectively dropped.
  always_comb begin
    resp_vis[0] = rvalid_q[0] && (state_q == StResp) && !rst;
    resp_vis[1] = rvalid_q[1] && (state_q == StResp) && !rst;

    bus_io.r0_gnt    = gnt0;
    bus_io.r1_gnt    = gnt1;
    bus_io.r0_rvalid = resp_vis[0];
    bus_io.r1_rvalid = resp_vis[1];
    bus_io.r0_err    = resp_vis[0] && err_q[0];
    bus_io.r1_err    = resp_vis[1] && err_q[1];
    bus_io.r0_rdata  = resp_vis[0] ? rdata_q[0] : 32'd0;
    bus_io.r1_rdata  = resp_vis[1] ? rdata_q[1] : 32'd0;

    bus_io.mem_write  = legal && sel_we;
    bus_io.mem_read   = legal && !sel_we;
    bus_io.mem_size   = legal ? sel_size  : 2'b00;
    bus_io.address    = legal ? sel_addr  : 32'd0;
    bus_io.write_data = legal ? sel_wdata : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte-array memory model.
// Honours DMEM_ARB_ALIGN_CHK_EN when choosing expectations for misaligned accesses.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];

  function automatic int size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    bus.read_data = 32'd0;
    if (bus.mem_read) begin
      for (int i = 0; i < size_bytes(bus.mem_size); i++) begin
        if (bus.address + 32'(i) < 32'd1024)
          bus.read_data[8*i +: 8] = mem[bus.address + 32'(i)];
      end
    end
  end

  always @(posedge clk) begin
    if (bus.mem_write) begin
      for (int i = 0; i < size_bytes(bus.mem_size); i++) begin
        if (bus.address + 32'(i) < 32'd1024)
          mem[bus.address + 32'(i)] <= bus.write_data[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
    bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_size = sz; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic req1(input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
    bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_size = sz; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_size = 2'b00; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_size = 2'b00; bus.r1_addr = '0; bus.r1_wdata = '0;

    // Reset: requests present but no grant or strobe while rst is high.
    rst = 1'b1;
    req0(1'b0, 2'b10, 32'h0, 32'h0);
    #1;
    chk("rst_gnt0", bus.r0_gnt, 1'b0);
    chk("rst_memrd", bus.mem_read, 1'b0);
    step();
    step();
    chk("rst_rvalid0", bus.r0_rvalid, 1'b0);
    chk("rst_rdata0", bus.r0_rdata, 32'h0);
    chk("rst_err1", bus.r1_err, 1'b0);
    bus.r0_req = 1'b0;
    rst = 1'b0;
    step();

    // Word write then word read at 0x10.
    req0(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    #1;
    chk("wr_gnt0", bus.r0_gnt, 1'b1);
    chk("wr_memwr", bus.mem_write, 1'b1);
    chk("wr_addr", bus.address, 32'h10);
    chk("wr_wdata", bus.write_data, 32'hDEADBEEF);
    step();
    chk("wr_rvalid0", bus.r0_rvalid, 1'b1);
    chk("wr_rdata0", bus.r0_rdata, 32'h0);
    chk("wr_err0", bus.r0_err, 1'b0);
    req0(1'b0, 2'b10, 32'h10, 32'h0);
    #1;
    chk("rd_gnt0", bus.r0_gnt, 1'b1);
    chk("rd_memrd", bus.mem_read, 1'b1);
    chk("rd_memwr", bus.mem_write, 1'b0);
    step();
    chk("rd_rvalid0", bus.r0_rvalid, 1'b1);
    chk("rd_rdata0", bus.r0_rdata, 32'hDEADBEEF);
    chk("rd_err0", bus.r0_err, 1'b0);
    bus.r0_req = 1'b0;
    #1;
    chk("idle_gnt0", bus.r0_gnt, 1'b0);
    chk("idle_memrd", bus.mem_read, 1'b0);
    chk("idle_addr", bus.address, 32'h0);
    step();
    chk("idle_rvalid0", bus.r0_rvalid, 1'b0);
    chk("idle_rdata0", bus.r0_rdata, 32'h0);

    // Contention straight after reset: 0,1,0,1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0(1'b0, 2'b10, 32'h10, 32'h0);
    req1(1'b0, 2'b10, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt0", bus.r0_gnt, (i % 2 == 0));
      chk("rr_gnt1", bus.r1_gnt, (i % 2 == 1));
      step();
      chk("rr_rvalid0", bus.r0_rvalid, (i % 2 == 0));
      chk("rr_rvalid1", bus.r1_rvalid, (i % 2 == 1));
      chk("rr_rdata", (i % 2 == 0) ? bus.r0_rdata : bus.r1_rdata, 32'hDEADBEEF);
    end
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    step();
    chk("rr_done_rv0", bus.r0_rvalid, 1'b0);
    chk("rr_done_rv1", bus.r1_rvalid, 1'b0);

    // Out-of-range word read at 0x3FE, then the last legal word at 0x3FC.
    req1(1'b0, 2'b10, 32'h3FE, 32'h0);
    #1;
    chk("oor_gnt1", bus.r1_gnt, 1'b1);
    chk("oor_memrd", bus.mem_read, 1'b0);
    step();
    chk("oor_rvalid1", bus.r1_rvalid, 1'b1);
    chk("oor_err1", bus.r1_err, 1'b1);
    chk("oor_rdata1", bus.r1_rdata, 32'h0);
    req1(1'b0, 2'b10, 32'h3FC, 32'h0);
    #1;
    chk("edge_memrd", bus.mem_read, 1'b1);
    chk("edge_addr", bus.address, 32'h3FC);
    step();
    chk("edge_err1", bus.r1_err, 1'b0);
    chk("edge_rvalid1", bus.r1_rvalid, 1'b1);
    bus.r1_req = 1'b0;

    // Misaligned half read at 0x11.
    req0(1'b0, 2'b01, 32'h11, 32'h0);
    #1;
    chk("mis_gnt0", bus.r0_gnt, 1'b1);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    chk("mis_memrd", bus.mem_read, 1'b0);
    step();
    chk("mis_err0", bus.r0_err, 1'b1);
    chk("mis_rdata0", bus.r0_rdata, 32'h0);
`else
    chk("mis_memrd", bus.mem_read, 1'b1);
    step();
    chk("mis_err0", bus.r0_err, 1'b0);
    chk("mis_rdata0", bus.r0_rdata, 32'h0000ADBE);
`endif
    chk("mis_rvalid0", bus.r0_rvalid, 1'b1);

    // Reserved size encoding.
    req0(1'b0, 2'b11, 32'h0, 32'h0);
    #1;
    chk("sz3_memrd", bus.mem_read, 1'b0);
    step();
    chk("sz3_err0", bus.r0_err, 1'b1);
    chk("sz3_rvalid0", bus.r0_rvalid, 1'b1);

    // Byte write from r0, byte read back from r1.
    req0(1'b1, 2'b00, 32'h20, 32'h123456A5);
    #1;
    chk("bw_memwr", bus.mem_write, 1'b1);
    chk("bw_size", bus.mem_size, 2'b00);
    step();
    bus.r0_req = 1'b0;
    req1(1'b0, 2'b00, 32'h20, 32'h0);
    #1;
    chk("br_gnt1", bus.r1_gnt, 1'b1);
    chk("br_memrd", bus.mem_read, 1'b1);
    step();
    chk("br_rdata1", bus.r1_rdata, 32'h000000A5);
    chk("br_rvalid0", bus.r0_rvalid, 1'b0);
    bus.r1_req = 1'b0;

    // Reset right after a grant drops the response and restores r0 priority.
    req0(1'b0, 2'b10, 32'h10, 32'h0);
    #1;
    chk("rg_gnt0", bus.r0_gnt, 1'b1);
    step();
    bus.r0_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rg_rvalid0_rst", bus.r0_rvalid, 1'b0);
    chk("rg_rdata0_rst", bus.r0_rdata, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("rg_rvalid0_after", bus.r0_rvalid, 1'b0);
    req0(1'b0, 2'b10, 32'h10, 32'h0);
    req1(1'b0, 2'b10, 32'h10, 32'h0);
    #1;
    chk("rg_gnt0", bus.r0_gnt, 1'b1);
    chk("rg_gnt1", bus.r1_gnt, 1'b0);
    step();
    chk("rg_rvalid0", bus.r0_rvalid, 1'b1);
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
